axi4lite_regfile_slave: RTL and testbench
=========================================

// Module: axi4lite_regfile_slave
//
// PURPOSE
//   Parametrised AXI4-Lite slave register file; the next-generation endpoint for the axi_if bundle.
//   Adds WSTRB byte enables, configurable register count, read-only register mask and SLVERR decode.
//   Independent read/write FSMs; sits behind the interconnect as a control/status register block.
//
// PARAMETERS
//   ADDR_WIDTH  6             byte-address width; must satisfy 2**ADDR_WIDTH >= NUM_REGS*DATA_WIDTH/8
//   DATA_WIDTH  32            data width, 32 or 64
//   NUM_REGS    8             implemented registers, 1..2**(ADDR_WIDTH-AL); AL=$clog2(DATA_WIDTH/8)
//   RO_MASK     '0 (NUM_REGS) bit i set -> register i read-only (writes dropped, SLVERR)
//   RST_VAL     '0            reset value of every register
//
// PORTS
//   ACLK     in   1            clock, all logic on rising edge
//   ARESETn  in   1            asynchronous active-low reset
//   AWADDR   in   ADDR_WIDTH   write address
//   AWVALID  in   1            write address valid
//   AWREADY  out  1            write address ready
//   WDATA    in   DATA_WIDTH   write data
//   WSTRB    in   DATA_WIDTH/8 byte enables
//   WVALID   in   1            write data valid
//   WREADY   out  1            write data ready
//   BRESP    out  2            write response, 00 OKAY / 10 SLVERR
//   BVALID   out  1            write response valid
//   BREADY   in   1            write response ready
//   ARADDR   in   ADDR_WIDTH   read address
//   ARVALID  in   1            read address valid
//   ARREADY  out  1            read address ready
//   RDATA    out  DATA_WIDTH   read data
//   RRESP    out  2            read response, 00 OKAY / 10 SLVERR
//   RVALID   out  1            read data valid
//   RREADY   in   1            read data ready
//
// BEHAVIOUR
//   - Reset: all outputs 0, registers = RST_VAL. AWREADY/WREADY/ARREADY rise at first edge after release.
//   - All outputs registered; no combinational input->output paths.
//   - Index = ADDR[ADDR_WIDTH-1:AL]; ADDR[AL-1:0] ignored (no unaligned error).
//   - Write FSM W_ACCEPT -> W_RESP -> W_ACCEPT.
//   - W_ACCEPT: AW and W captured independently in any order. AWREADY drops after AW handshake, WREADY after W.
//   - Commit occurs at the edge where both are held; that same edge sets BVALID (AW+W same edge N -> BVALID at N+1).
//   - Commit updates byte b iff WSTRB[b] and index<NUM_REGS and !RO_MASK[index]; otherwise no update, BRESP=10.
//   - WSTRB=0 to a valid RW register: no change, BRESP=00.
//   - W_RESP: BVALID/BRESP stable until BREADY; on B handshake, BVALID=0 and AWREADY=WREADY=1 next cycle.
//   - Read FSM R_ACCEPT -> R_DATA -> R_ACCEPT.
//   - AR handshake at edge N: ARREADY=0 and RVALID=1 at N+1. RDATA=register (index<NUM_REGS, RRESP=00) else 0 with RRESP=10.
//   - RDATA/RRESP stable until RREADY; on R handshake, RVALID=0 and ARREADY=1.
//   - Read and write channels are fully concurrent.
//   - Read AR handshake on the same edge as a write commit to the same register returns the pre-write value.
//   - Back-to-back throughput: one write per 2 cycles min, one read per 2 cycles min.
//   - VALID dropped before handshake: not legal master behaviour; captured state is unaffected.
//   - Reset mid-transaction: FSMs abort to idle, pending response discarded, registers = RST_VAL.
//
// TESTING
//   - Reset: after ARESETn release, cycle 1 AWREADY=WREADY=ARREADY=1, BVALID=RVALID=0; read reg0 -> 0x0, OKAY.
//   - Write 0xDEADBEEF to 0x04 (WSTRB=F, AW+W same cycle), BREADY=1 -> BVALID next cycle, OKAY; read 0x04 -> 0xDEADBEEF.
//   - Partial strobe: write 0x11223344 WSTRB=0101 over 0xDEADBEEF -> read returns 0xDE22BE44.
//   - W three cycles before AW; BREADY held low 5 cycles -> BVALID/BRESP stable 5 cycles, single commit.
//   - Address 0x20 (index 8, NUM_REGS=8) write -> SLVERR, no register changes; read -> RDATA 0, RRESP=10.
//   - RO_MASK bit2 set: write 0x08 -> SLVERR, value kept.
//   - Same-edge read+write of reg3 -> old data; next read gets new data.
//   - ARESETn pulse during W_RESP -> BVALID=0 immediately, all regs 0.

Source files
------------

// File: rtl/axi4lite_regfile_slave.sv
// AXI4-Lite slave register file with byte strobes, read-only mask and SLVERR decode.
// The write and read channels each run their own two-state FSM and are fully concurrent.
module axi4lite_regfile_slave #(
  parameter int unsigned           ADDR_WIDTH = 6,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           NUM_REGS   = 8,
  parameter logic [NUM_REGS-1:0]   RO_MASK    = '0,
  parameter logic [DATA_WIDTH-1:0] RST_VAL    = '0
) (
  input  logic                    ACLK,
  input  logic                    ARESETn,
  input  logic [ADDR_WIDTH-1:0]   AWADDR,
  input  logic                    AWVALID,
  output logic                    AWREADY,
  input  logic [DATA_WIDTH-1:0]   WDATA,
  input  logic [DATA_WIDTH/8-1:0] WSTRB,
  input  logic                    WVALID,
  output logic                    WREADY,
  output logic [1:0]              BRESP,
  output logic                    BVALID,
  input  logic                    BREADY,
  input  logic [ADDR_WIDTH-1:0]   ARADDR,
  input  logic                    ARVALID,
  output logic                    ARREADY,
  output logic [DATA_WIDTH-1:0]   RDATA,
  output logic [1:0]              RRESP,
  output logic                    RVALID,
  input  logic                    RREADY
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam int unsigned AL     = $clog2(STRB_W);
  localparam int unsigned IDX_W  = ADDR_WIDTH - AL;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {W_ACCEPT, W_RESP} wstate_t;
  typedef enum logic {R_ACCEPT, R_DATA} rstate_t;

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  // Write channel state
  wstate_t               wstate_q, wstate_d;
  logic                  aw_held_q, aw_held_d;
  logic                  w_held_q, w_held_d;
  logic [IDX_W-1:0]      awidx_q, awidx_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0]     wstrb_q, wstrb_d;
  logic                  awready_d, wready_d, bvalid_d;
  logic [1:0]            bresp_d;
  logic                  aw_hs, w_hs, commit, wr_hit, wr_ro;
  logic [IDX_W-1:0]      cm_idx;
  logic [DATA_WIDTH-1:0] cm_data;
  logic [STRB_W-1:0]     cm_strb;

  // Read channel state
  rstate_t               rstate_q, rstate_d;
  logic                  arready_d, rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_d;
  logic [1:0]            rresp_d;
  logic                  ar_hs, rd_hit;
  logic [IDX_W-1:0]      ar_idx;
  logic [DATA_WIDTH-1:0] rd_val;

  // Sub-word address bits carry no meaning; accesses are always word aligned.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{AWADDR[AL-1:0], ARADDR[AL-1:0]};

  // Write FSM next-state: capture AW and W independently, commit once both are in hand.
  always_comb begin
    wstate_d  = wstate_q;
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    awidx_d   = awidx_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    awready_d = AWREADY;
    wready_d  = WREADY;
    bvalid_d  = BVALID;
    bresp_d   = BRESP;
    commit    = 1'b0;
    aw_hs     = AWVALID && AWREADY;
    w_hs      = WVALID && WREADY;
    cm_idx    = aw_hs ? AWADDR[ADDR_WIDTH-1:AL] : awidx_q;
    cm_data   = w_hs ? WDATA : wdata_q;
    cm_strb   = w_hs ? WSTRB : wstrb_q;
    wr_hit    = 1'b0;
    wr_ro     = 1'b0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (cm_idx == IDX_W'(i)) begin
        wr_hit = 1'b1;
        wr_ro  = RO_MASK[i];
      end
    end
    case (wstate_q)
      W_ACCEPT: begin
        if (aw_hs) begin
          aw_held_d = 1'b1;
          awidx_d   = AWADDR[ADDR_WIDTH-1:AL];
        end
        if (w_hs) begin
          w_held_d = 1'b1;
          wdata_d  = WDATA;
          wstrb_d  = WSTRB;
        end
        if ((aw_held_q || aw_hs) && (w_held_q || w_hs)) begin
          commit    = 1'b1;
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          awready_d = 1'b0;
          wready_d  = 1'b0;
          bvalid_d  = 1'b1;
          bresp_d   = (wr_hit && !wr_ro) ? RESP_OKAY : RESP_SLVERR;
          wstate_d  = W_RESP;
        end else begin
          awready_d = !(aw_held_q || aw_hs);
          wready_d  = !(w_held_q || w_hs);
        end
      end
      W_RESP: begin
        if (BREADY) begin
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
          wready_d  = 1'b1;
          wstate_d  = W_ACCEPT;
        end
      end
      default: wstate_d = W_ACCEPT;
    endcase
  end

  // Write FSM state and registered write-channel outputs.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      wstate_q  <= W_ACCEPT;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      awidx_q   <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      AWREADY   <= 1'b0;
      WREADY    <= 1'b0;
      BVALID    <= 1'b0;
      BRESP     <= 2'b00;
    end else begin
      wstate_q  <= wstate_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      awidx_q   <= awidx_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      AWREADY   <= awready_d;
      WREADY    <= wready_d;
      BVALID    <= bvalid_d;
      BRESP     <= bresp_d;
    end
  end

  // Register array: strobed byte update on an accepted commit to a writable register.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= RST_VAL;
    end else if (commit && wr_hit && !wr_ro) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (cm_idx == IDX_W'(i)) begin
          for (int unsigned b = 0; b < STRB_W; b++) begin
            if (cm_strb[b]) regs[i][8*b +: 8] <= cm_data[8*b +: 8];
          end
        end
      end
    end
  end

  // Read FSM next-state: sample the register on the AR handshake, hold until R handshake.
  always_comb begin
    rstate_d  = rstate_q;
    arready_d = ARREADY;
    rvalid_d  = RVALID;
    rdata_d   = RDATA;
    rresp_d   = RRESP;
    ar_hs     = ARVALID && ARREADY;
    ar_idx    = ARADDR[ADDR_WIDTH-1:AL];
    rd_hit    = 1'b0;
    rd_val    = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (ar_idx == IDX_W'(i)) begin
        rd_hit = 1'b1;
        rd_val = regs[i];
      end
    end
    case (rstate_q)
      R_ACCEPT: begin
        if (ar_hs) begin
          arready_d = 1'b0;
          rvalid_d  = 1'b1;
          rdata_d   = rd_val;
          rresp_d   = rd_hit ? RESP_OKAY : RESP_SLVERR;
          rstate_d  = R_DATA;
        end else begin
          arready_d = 1'b1;
        end
      end
      R_DATA: begin
        if (RREADY) begin
          rvalid_d  = 1'b0;
          arready_d = 1'b1;
          rstate_d  = R_ACCEPT;
        end
      end
      default: rstate_d = R_ACCEPT;
    endcase
  end

  // Read FSM state and registered read-channel outputs.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      rstate_q <= R_ACCEPT;
      ARREADY  <= 1'b0;
      RVALID   <= 1'b0;
      RDATA    <= '0;
      RRESP    <= 2'b00;
    end else begin
      rstate_q <= rstate_d;
      ARREADY  <= arready_d;
      RVALID   <= rvalid_d;
      RDATA    <= rdata_d;
      RRESP    <= rresp_d;
    end
  end

endmodule

// File: tb/tb_axi4lite_regfile_slave.sv
// Self-checking bench for axi4lite_regfile_slave: directed scenarios plus random traffic
// checked against an array-based register model.
module tb_axi4lite_regfile_slave;

  localparam int unsigned AW = 6;
  localparam int unsigned DW = 32;
  localparam int unsigned NR = 8;
  localparam logic [NR-1:0] RO = 8'h04;

  logic          ACLK = 1'b0;
  logic          ARESETn;
  logic [AW-1:0] AWADDR;
  logic          AWVALID, AWREADY;
  logic [DW-1:0] WDATA;
  logic [3:0]    WSTRB;
  logic          WVALID, WREADY;
  logic [1:0]    BRESP;
  logic          BVALID, BREADY;
  logic [AW-1:0] ARADDR;
  logic          ARVALID, ARREADY;
  logic [DW-1:0] RDATA;
  logic [1:0]    RRESP;
  logic          RVALID, RREADY;

  always #5 ACLK = ~ACLK;

  axi4lite_regfile_slave #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR), .RO_MASK(RO), .RST_VAL('0)
  ) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
  );

  logic [31:0] model [NR];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // A write succeeds only on an implemented, writable register.
  function automatic logic [1:0] exp_wresp(input logic [AW-1:0] a);
    int idx;
    idx = int'(a) / 4;
    if (idx < int'(NR)) begin
      if (!RO[idx]) return 2'b00;
    end
    return 2'b10;
  endfunction

  function automatic logic [1:0] exp_rresp(input logic [AW-1:0] a);
    return ((int'(a) / 4) < int'(NR)) ? 2'b00 : 2'b10;
  endfunction

  function automatic logic [31:0] exp_rdata(input logic [AW-1:0] a);
    int idx;
    idx = int'(a) / 4;
    return (idx < int'(NR)) ? model[idx] : 32'h0;
  endfunction

  task automatic model_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s);
    int idx;
    idx = int'(a) / 4;
    if (exp_wresp(a) == 2'b00) begin
      for (int b = 0; b < 4; b++) if (s[b]) model[idx][8*b +: 8] = d[8*b +: 8];
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < int'(NR); i++) model[i] = 32'h0;
  endtask

  // Full write transaction with BREADY high; lat = cycles from issue to BVALID seen.
  task automatic do_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic [1:0] resp, output int lat);
    logic done, aw_f, w_f, b_f;
    done = 1'b0; lat = -1; resp = 2'bxx;
    @(negedge ACLK);
    AWADDR = a; WDATA = d; WSTRB = s; AWVALID = 1'b1; WVALID = 1'b1; BREADY = 1'b1;
    for (int c = 0; c < 20 && !done; c++) begin
      aw_f = AWVALID && AWREADY;
      w_f  = WVALID && WREADY;
      b_f  = BVALID && BREADY;
      if (b_f) begin resp = BRESP; lat = c; end
      @(posedge ACLK);
      @(negedge ACLK);
      if (aw_f) AWVALID = 1'b0;
      if (w_f)  WVALID  = 1'b0;
      if (b_f)  done    = 1'b1;
    end
    AWVALID = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
    chk("wr_done", 64'(done), 64'd1);
  endtask

  task automatic do_read(input logic [AW-1:0] a, output logic [31:0] d, output logic [1:0] resp,
                         output int lat);
    logic done, ar_f, r_f;
    done = 1'b0; lat = -1; resp = 2'bxx; d = 'x;
    @(negedge ACLK);
    ARADDR = a; ARVALID = 1'b1; RREADY = 1'b1;
    for (int c = 0; c < 20 && !done; c++) begin
      ar_f = ARVALID && ARREADY;
      r_f  = RVALID && RREADY;
      if (r_f) begin d = RDATA; resp = RRESP; lat = c; end
      @(posedge ACLK);
      @(negedge ACLK);
      if (ar_f) ARVALID = 1'b0;
      if (r_f)  done    = 1'b1;
    end
    ARVALID = 1'b0; RREADY = 1'b0;
    chk("rd_done", 64'(done), 64'd1);
  endtask

  task automatic cyc();
    @(posedge ACLK);
    @(negedge ACLK);
  endtask

  initial begin
    logic [1:0]  resp;
    logic [31:0] rd, d, old3;
    logic [AW-1:0] a;
    logic [3:0]  s;
    int lat;

    ARESETn = 1'b0;
    AWADDR = '0; AWVALID = 1'b0; WDATA = '0; WSTRB = '0; WVALID = 1'b0; BREADY = 1'b0;
    ARADDR = '0; ARVALID = 1'b0; RREADY = 1'b0;
    model_reset();

    // Reset: outputs low while held, readies rise on first edge after release.
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    chk("rst_awready_low", 64'(AWREADY), 64'd0);
    chk("rst_bvalid_low", 64'(BVALID), 64'd0);
    ARESETn = 1'b1;
    cyc();
    chk("rel_awready", 64'(AWREADY), 64'd1);
    chk("rel_wready", 64'(WREADY), 64'd1);
    chk("rel_arready", 64'(ARREADY), 64'd1);
    chk("rel_bvalid", 64'(BVALID), 64'd0);
    chk("rel_rvalid", 64'(RVALID), 64'd0);
    do_read(6'h00, rd, resp, lat);
    chk("rd0_data", 64'(rd), 64'h0);
    chk("rd0_resp", 64'(resp), 64'd0);
    chk("rd0_lat", 64'(lat), 64'd1);

    // Full-strobe write, AW and W together.
    do_write(6'h04, 32'hDEADBEEF, 4'hF, resp, lat);
    model_write(6'h04, 32'hDEADBEEF, 4'hF);
    chk("wr4_resp", 64'(resp), 64'd0);
    chk("wr4_lat", 64'(lat), 64'd1);
    do_read(6'h04, rd, resp, lat);
    chk("rd4_data", 64'(rd), 64'hDEADBEEF);

    // Partial strobe merge.
    do_write(6'h04, 32'h11223344, 4'b0101, resp, lat);
    model_write(6'h04, 32'h11223344, 4'b0101);
    chk("wr4p_resp", 64'(resp), 64'd0);
    do_read(6'h04, rd, resp, lat);
    chk("rd4p_data", 64'(rd), 64'hDE22BE44);
    chk("rd4p_model", 64'(rd), 64'(exp_rdata(6'h04)));

    // Zero strobe: OKAY, no change.
    do_write(6'h04, 32'hFFFFFFFF, 4'h0, resp, lat);
    chk("wr4z_resp", 64'(resp), 64'd0);
    do_read(6'h04, rd, resp, lat);
    chk("rd4z_data", 64'(rd), 64'hDE22BE44);

    // W three cycles ahead of AW, BREADY held low for five cycles.
    d = $urandom;
    @(negedge ACLK);
    WDATA = d; WSTRB = 4'hF; WVALID = 1'b1; BREADY = 1'b0;
    cyc();
    WVALID = 1'b0;
    chk("wfirst_wready_low", 64'(WREADY), 64'd0);
    chk("wfirst_awready_high", 64'(AWREADY), 64'd1);
    chk("wfirst_no_bvalid", 64'(BVALID), 64'd0);
    cyc();
    cyc();
    AWADDR = 6'h14; AWVALID = 1'b1;
    cyc();
    AWVALID = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("bhold_valid", 64'(BVALID), 64'd1);
      chk("bhold_resp", 64'(BRESP), 64'd0);
      cyc();
    end
    BREADY = 1'b1;
    cyc();
    BREADY = 1'b0;
    chk("bdone_bvalid", 64'(BVALID), 64'd0);
    chk("bdone_awready", 64'(AWREADY), 64'd1);
    chk("bdone_wready", 64'(WREADY), 64'd1);
    model_write(6'h14, d, 4'hF);
    do_read(6'h14, rd, resp, lat);
    chk("rd5_data", 64'(rd), 64'(d));

    // Unimplemented index 8.
    do_write(6'h20, 32'hA5A5A5A5, 4'hF, resp, lat);
    chk("wr20_resp", 64'(resp), 64'd2);
    do_read(6'h20, rd, resp, lat);
    chk("rd20_data", 64'(rd), 64'h0);
    chk("rd20_resp", 64'(resp), 64'd2);

    // Read-only register 2.
    do_write(6'h08, 32'h12345678, 4'hF, resp, lat);
    chk("wr8_resp", 64'(resp), 64'd2);
    do_read(6'h08, rd, resp, lat);
    chk("rd8_data", 64'(rd), 64'h0);
    chk("rd8_resp", 64'(resp), 64'd0);

    // Same-edge read and write of register 3.
    old3 = $urandom;
    do_write(6'h0C, old3, 4'hF, resp, lat);
    model_write(6'h0C, old3, 4'hF);
    d = ~old3;
    @(negedge ACLK);
    AWADDR = 6'h0C; WDATA = d; WSTRB = 4'hF; AWVALID = 1'b1; WVALID = 1'b1; BREADY = 1'b1;
    ARADDR = 6'h0C; ARVALID = 1'b1; RREADY = 1'b1;
    cyc();
    AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
    chk("same_rvalid", 64'(RVALID), 64'd1);
    chk("same_rdata_old", 64'(RDATA), 64'(old3));
    chk("same_bvalid", 64'(BVALID), 64'd1);
    cyc();
    BREADY = 1'b0; RREADY = 1'b0;
    chk("same_rvalid_done", 64'(RVALID), 64'd0);
    model_write(6'h0C, d, 4'hF);
    do_read(6'h0C, rd, resp, lat);
    chk("same_rdata_new", 64'(rd), 64'(d));

    // Random traffic against the model, including unaligned and out-of-range addresses.
    for (int n = 0; n < 60; n++) begin
      a = AW'($urandom_range(0, 63));
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom;
        s = 4'($urandom_range(0, 15));
        do_write(a, d, s, resp, lat);
        chk("rnd_wresp", 64'(resp), 64'(exp_wresp(a)));
        model_write(a, d, s);
      end else begin
        do_read(a, rd, resp, lat);
        chk("rnd_rresp", 64'(resp), 64'(exp_rresp(a)));
        chk("rnd_rdata", 64'(rd), 64'(exp_rdata(a)));
      end
    end

    // Reset pulse while a response is pending.
    @(negedge ACLK);
    AWADDR = 6'h04; WDATA = $urandom | 32'h1; WSTRB = 4'hF; AWVALID = 1'b1; WVALID = 1'b1;
    BREADY = 1'b0;
    cyc();
    AWVALID = 1'b0; WVALID = 1'b0;
    chk("prerst_bvalid", 64'(BVALID), 64'd1);
    #2 ARESETn = 1'b0;
    #1;
    chk("midrst_bvalid", 64'(BVALID), 64'd0);
    chk("midrst_awready", 64'(AWREADY), 64'd0);
    @(negedge ACLK);
    ARESETn = 1'b1;
    model_reset();
    cyc();
    chk("postrst_awready", 64'(AWREADY), 64'd1);
    chk("postrst_bvalid", 64'(BVALID), 64'd0);
    for (int i = 0; i < int'(NR); i++) begin
      do_read(AW'(i * 4), rd, resp, lat);
      chk("postrst_rdata", 64'(rd), 64'(exp_rdata(AW'(i * 4))));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
